// File: rtl/preg_free_list.sv
`default_nettype none
// ============================================================================
// Module      : preg_free_list
// Description : Physical-register free list for rename. Circular FIFO of free
//               tags, two in-order allocation slots, two retire release slots.
//               Optional stall counter: define PREG_FREE_LIST_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module preg_free_list #(
   parameter int NUM_PREGS = 64,
   parameter int NUM_ARCH  = 32,
   parameter int TAG_W     = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc0_req,
   input  logic             alloc1_req,
   output logic             alloc0_gnt,
   output logic [TAG_W-1:0] alloc0_tag,
   output logic             alloc1_gnt,
   output logic [TAG_W-1:0] alloc1_tag,
   input  logic             rel0_valid,
   input  logic [TAG_W-1:0] rel0_tag,
   input  logic             rel1_valid,
   input  logic [TAG_W-1:0] rel1_tag,
   output logic [TAG_W:0]   free_count,
   output logic             empty,
   output logic             err_overflow
`ifdef PREG_FREE_LIST_STATS_EN
   ,
   output logic [15:0]      stall_cnt
`endif
);

   localparam logic [TAG_W:0]   c_one         = (TAG_W+1)'(1);
   localparam logic [TAG_W:0]   c_two         = (TAG_W+1)'(2);
   localparam logic [TAG_W:0]   c_full        = (TAG_W+1)'(NUM_PREGS);
   localparam logic [TAG_W:0]   c_reset_count = (TAG_W+1)'(NUM_PREGS - NUM_ARCH);
   localparam logic [TAG_W-1:0] c_reset_tail  = TAG_W'(NUM_PREGS - NUM_ARCH);

   logic [TAG_W-1:0] r_fifo [NUM_PREGS];
   logic [TAG_W-1:0] r_head;
   logic [TAG_W-1:0] r_tail;
   logic [TAG_W:0]   r_count;
   logic             r_err;

   logic             w_gnt0;
   logic             w_gnt1;
   logic [1:0]       w_n_grant;
   logic [1:0]       w_n_acc;
   logic [TAG_W:0]   w_base;
   logic             w_acc0;
   logic             w_acc1;
   logic             w_reject;
   logic [TAG_W-1:0] w_head_p1;
   logic [TAG_W-1:0] w_tail_p1;
   logic [TAG_W-1:0] w_rel1_idx;

   assign w_head_p1 = r_head + TAG_W'(1);
   assign w_tail_p1 = r_tail + TAG_W'(1);

   // Grants look only at the registered count; slot 1 never overtakes slot 0.
   always_comb begin
      w_gnt0 = 1'b0;
      w_gnt1 = 1'b0;
      if (!rst) begin
         w_gnt0 = alloc0_req && (r_count >= c_one);
         if (alloc0_req)
            w_gnt1 = alloc1_req && (r_count >= c_two);
         else
            w_gnt1 = alloc1_req && (r_count >= c_one);
      end
   end

   assign alloc0_gnt = w_gnt0;
   assign alloc1_gnt = w_gnt1;
   assign alloc0_tag = r_fifo[r_head];
   assign alloc1_tag = alloc0_req ? r_fifo[w_head_p1] : r_fifo[r_head];

   assign w_n_grant = {1'b0, w_gnt0} + {1'b0, w_gnt1};

   // Room for a release is judged after this cycle's pops are taken out.
   assign w_base     = r_count - (TAG_W+1)'(w_n_grant);
   assign w_acc0     = rel0_valid && (w_base < c_full);
   assign w_acc1     = rel1_valid && ((w_base + (TAG_W+1)'(w_acc0)) < c_full);
   assign w_reject   = (rel0_valid && !w_acc0) || (rel1_valid && !w_acc1);
   assign w_n_acc    = {1'b0, w_acc0} + {1'b0, w_acc1};
   assign w_rel1_idx = w_acc0 ? w_tail_p1 : r_tail;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_PREGS; i++)
            r_fifo[i] <= (i < NUM_PREGS - NUM_ARCH) ? TAG_W'(NUM_ARCH + i) : '0;
         r_head  <= '0;
         r_tail  <= c_reset_tail;
         r_count <= c_reset_count;
         r_err   <= 1'b0;
      end else begin
         if (w_acc0)
            r_fifo[r_tail] <= rel0_tag;
         if (w_acc1)
            r_fifo[w_rel1_idx] <= rel1_tag;
         r_head  <= r_head + TAG_W'(w_n_grant);
         r_tail  <= r_tail + TAG_W'(w_n_acc);
         r_count <= r_count + (TAG_W+1)'(w_n_acc) - (TAG_W+1)'(w_n_grant);
         if (w_reject)
            r_err <= 1'b1;
      end
   end

   assign free_count   = r_count;
   assign empty        = (r_count == '0);
   assign err_overflow = r_err;

`ifdef PREG_FREE_LIST_STATS_EN
   logic        w_stall;
   logic [15:0] r_stall_cnt;

   assign w_stall = (alloc0_req && !w_gnt0) || (alloc1_req && !w_gnt1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         r_stall_cnt <= '0;
      else if (w_stall && (r_stall_cnt != 16'hFFFF))
         r_stall_cnt <= r_stall_cnt + 16'd1;
   end

   assign stall_cnt = r_stall_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_preg_free_list.sv
`default_nettype none
// ============================================================================
// Module      : tb_preg_free_list
// Description : Self-checking bench for preg_free_list with a queue-based
//               free-list model and a scoreboard of expected grants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_preg_free_list;

   localparam int TAG_W = 6;

   typedef struct {
      logic             g0;
      logic [TAG_W-1:0] t0;
      logic             g1;
      logic [TAG_W-1:0] t1;
   } exp_t;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             alloc0_req = 1'b0;
   logic             alloc1_req = 1'b0;
   logic             alloc0_gnt;
   logic [TAG_W-1:0] alloc0_tag;
   logic             alloc1_gnt;
   logic [TAG_W-1:0] alloc1_tag;
   logic             rel0_valid = 1'b0;
   logic [TAG_W-1:0] rel0_tag = '0;
   logic             rel1_valid = 1'b0;
   logic [TAG_W-1:0] rel1_tag = '0;
   logic [TAG_W:0]   free_count;
   logic             empty;
   logic             err_overflow;
`ifdef PREG_FREE_LIST_STATS_EN
   logic [15:0]      stall_cnt;
`endif

   preg_free_list dut (
      .clk          (clk),
      .rst          (rst),
      .alloc0_req   (alloc0_req),
      .alloc1_req   (alloc1_req),
      .alloc0_gnt   (alloc0_gnt),
      .alloc0_tag   (alloc0_tag),
      .alloc1_gnt   (alloc1_gnt),
      .alloc1_tag   (alloc1_tag),
      .rel0_valid   (rel0_valid),
      .rel0_tag     (rel0_tag),
      .rel1_valid   (rel1_valid),
      .rel1_tag     (rel1_tag),
      .free_count   (free_count),
      .empty        (empty),
      .err_overflow (err_overflow)
`ifdef PREG_FREE_LIST_STATS_EN
      ,
      .stall_cnt    (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   int   n_checks = 0;
   int   n_pass   = 0;
   int   mq[$];
   int   inflight[$];
   exp_t exp_q[$];
   int   mstall = 0;

   logic             og0, og1;
   logic [TAG_W-1:0] ot0, ot1;

   // Reference model: free tags held in a plain queue, pops before pushes.
   task automatic model_reset();
      mq.delete();
      for (int i = 32; i < 64; i++) mq.push_back(i);
      exp_q.delete();
      mstall = 0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      alloc0_req = 0; alloc1_req = 0; rel0_valid = 0; rel1_valid = 0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
   endtask

   // Drive one cycle, push the model's expectation, capture DUT outputs.
   task automatic step(input bit a0, input bit a1, input bit v0, input int t0,
                       input bit v1, input int t1);
      exp_t e;
      alloc0_req = a0; alloc1_req = a1;
      rel0_valid = v0; rel0_tag = TAG_W'(t0);
      rel1_valid = v1; rel1_tag = TAG_W'(t1);
      e.g0 = a0 && (mq.size() >= 1);
      e.g1 = a1 && (a0 ? (mq.size() >= 2) : (mq.size() >= 1));
      e.t0 = '0; e.t1 = '0;
      if (e.g0) e.t0 = TAG_W'(mq.pop_front());
      if (e.g1) e.t1 = TAG_W'(mq.pop_front());
      if (v0) begin
         if (mq.size() < 64) mq.push_back(t0);
      end
      if (v1) begin
         if (mq.size() < 64) mq.push_back(t1);
      end
      if (((a0 && !e.g0) || (a1 && !e.g1)) && mstall < 65535) mstall++;
      exp_q.push_back(e);
      @(negedge clk);
      og0 = alloc0_gnt; og1 = alloc1_gnt; ot0 = alloc0_tag; ot1 = alloc1_tag;
      @(posedge clk);
      #1;
      alloc0_req = 0; alloc1_req = 0; rel0_valid = 0; rel1_valid = 0;
   endtask

   task automatic test_reset();
      alloc0_req = 1; alloc1_req = 1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if ({alloc0_gnt, alloc1_gnt} !== 2'b00)
         $display("FAIL reset_gnt_low: got %b exp 00", {alloc0_gnt, alloc1_gnt});
      else n_pass++;
      @(posedge clk);
      #1 rst = 1'b0;
      model_reset();
      @(negedge clk);
      n_checks++;
      if (free_count !== 7'd32) $display("FAIL reset_count: got %0d exp 32", free_count);
      else n_pass++;
      n_checks++;
      if (empty !== 1'b0 || err_overflow !== 1'b0)
         $display("FAIL reset_flags: got empty=%b err=%b exp 0 0", empty, err_overflow);
      else n_pass++;
      n_checks++;
      if (alloc0_tag !== 6'd32 || alloc1_tag !== 6'd33 || alloc0_gnt !== 1'b1 || alloc1_gnt !== 1'b1)
         $display("FAIL reset_tags: got %0d/%0d gnt %b%b exp 32/33 gnt 11",
                  alloc0_tag, alloc1_tag, alloc0_gnt, alloc1_gnt);
      else n_pass++;
      #1 alloc0_req = 0; alloc1_req = 0;
      @(posedge clk);
      #1;
   endtask

   task automatic test_drain();
      exp_t e;
      for (int c = 0; c < 17; c++) begin
         step(1, 1, 0, 0, 0, 0);
         e = exp_q.pop_front();
         n_checks++;
         if (og0 !== e.g0 || og1 !== e.g1 || (e.g0 && ot0 !== e.t0) || (e.g1 && ot1 !== e.t1))
            $display("FAIL drain_c%0d: got g%b%b t%0d/%0d exp g%b%b t%0d/%0d",
                     c, og0, og1, ot0, ot1, e.g0, e.g1, e.t0, e.t1);
         else n_pass++;
         if (c < 16) begin
            n_checks++;
            if (ot0[0] !== 1'b0) $display("FAIL drain_even_c%0d: got tag %0d exp even", c, ot0);
            else n_pass++;
         end
      end
      n_checks++;
      if (free_count !== 7'd0 || empty !== 1'b1)
         $display("FAIL drain_empty: got count=%0d empty=%b exp 0 1", free_count, empty);
      else n_pass++;
   endtask

   task automatic test_empty_release();
      exp_t e;
      step(0, 1, 1, 5, 0, 0);
      e = exp_q.pop_front();
      n_checks++;
      if (og1 !== 1'b0 || e.g1 !== 1'b0) $display("FAIL empty_rel_n: got gnt1=%b exp 0", og1);
      else n_pass++;
      step(0, 1, 0, 0, 0, 0);
      e = exp_q.pop_front();
      n_checks++;
      if (og1 !== 1'b1 || ot1 !== 6'd5) $display("FAIL empty_rel_n1: got gnt1=%b tag %0d exp 1 tag 5", og1, ot1);
      else n_pass++;
   endtask

   task automatic test_count_one();
      exp_t e;
      step(0, 0, 1, 7, 0, 0);
      void'(exp_q.pop_front());
      step(1, 1, 0, 0, 0, 0);
      e = exp_q.pop_front();
      n_checks++;
      if (og0 !== 1'b1 || ot0 !== 6'd7 || og1 !== 1'b0)
         $display("FAIL count1_both: got g%b%b tag %0d exp g10 tag 7", og0, og1, ot0);
      else n_pass++;
      step(0, 0, 1, 9, 0, 0);
      void'(exp_q.pop_front());
      step(0, 1, 0, 0, 0, 0);
      e = exp_q.pop_front();
      n_checks++;
      if (og1 !== 1'b1 || ot1 !== 6'd9 || og0 !== 1'b0)
         $display("FAIL count1_slot1: got g%b%b tag %0d exp g01 tag 9", og0, og1, ot1);
      else n_pass++;
   endtask

   task automatic test_overflow();
      do_reset();
      for (int i = 0; i < 16; i++) begin
         step(0, 0, 1, 2*i, 1, 2*i+1);
         void'(exp_q.pop_front());
      end
      n_checks++;
      if (free_count !== 7'd64 || err_overflow !== 1'b0)
         $display("FAIL ovf_full: got count=%0d err=%b exp 64 0", free_count, err_overflow);
      else n_pass++;
      step(0, 0, 1, 40, 0, 0);
      void'(exp_q.pop_front());
      repeat (3) @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (free_count !== 7'd64 || err_overflow !== 1'b1)
         $display("FAIL ovf_drop: got count=%0d err=%b exp 64 1", free_count, err_overflow);
      else n_pass++;
      @(posedge clk);
      #1;
   endtask

   task automatic test_stream();
      exp_t e;
      bit   v0, v1;
      int   t0, t1;
      do_reset();
      @(negedge clk);
      n_checks++;
      if (err_overflow !== 1'b0) $display("FAIL stream_err_cleared: got %b exp 0", err_overflow);
      else n_pass++;
      @(posedge clk);
      #1;
      for (int c = 0; c < 200; c++) begin
         v0 = (inflight.size() > 0) && ($urandom_range(0, 3) != 0);
         t0 = v0 ? inflight.pop_front() : 0;
         v1 = (inflight.size() > 0) && ($urandom_range(0, 2) == 0);
         t1 = v1 ? inflight.pop_front() : 0;
         step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v0, t0, v1, t1);
         e = exp_q.pop_front();
         if (e.g0) inflight.push_back(int'(e.t0));
         if (e.g1) inflight.push_back(int'(e.t1));
         n_checks++;
         if (og0 !== e.g0 || og1 !== e.g1 || (e.g0 && ot0 !== e.t0) || (e.g1 && ot1 !== e.t1))
            $display("FAIL stream_c%0d: got g%b%b t%0d/%0d exp g%b%b t%0d/%0d",
                     c, og0, og1, ot0, ot1, e.g0, e.g1, e.t0, e.t1);
         else n_pass++;
         n_checks++;
         if (free_count !== 7'(mq.size()))
            $display("FAIL stream_count_c%0d: got %0d exp %0d", c, free_count, mq.size());
         else n_pass++;
      end
      n_checks++;
      if (err_overflow !== 1'b0) $display("FAIL stream_err: got %b exp 0", err_overflow);
      else n_pass++;
`ifdef PREG_FREE_LIST_STATS_EN
      n_checks++;
      if (stall_cnt !== 16'(mstall)) $display("FAIL stream_stall: got %0d exp %0d", stall_cnt, mstall);
      else n_pass++;
`endif
   endtask

   initial begin
      model_reset();
      test_reset();
      test_drain();
      test_empty_release();
      test_count_one();
      test_overflow();
      test_stream();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/preg_free_list.md
# preg_free_list

Physical-register free-list allocator for the rename stage of the out-of-order core. Owns the pool of 64 physical register tags and arbitrates it between two in-order rename slots (allocation) and two retire slots (release). It hands out free tags as destination registers the same cycle they are requested, and reclaims tags freed at retire. It sits beside the RAT, between decode/rename and retire.

## Interface
- NUM_PREGS, 64, physical registers in the pool (power of two)
- NUM_ARCH, 32, architectural registers; tags 0..NUM_ARCH-1 are mapped at reset
- TAG_W, 6, tag width, log2(NUM_PREGS)

- clk  in  1  clock, all state updates on posedge
- rst  in  1  asynchronous, active-high reset
- alloc0_req  in  1  rename slot 0 (older instruction) requests a destination tag
- alloc1_req  in  1  rename slot 1 (younger instruction) requests a destination tag
- alloc0_gnt  out  1  slot 0 granted this cycle (combinational)
- alloc0_tag  out  TAG_W  tag for slot 0, valid when alloc0_gnt
- alloc1_gnt  out  1  slot 1 granted this cycle (combinational)
- alloc1_tag  out  TAG_W  tag for slot 1, valid when alloc1_gnt
- rel0_valid  in  1  retire slot 0 releases rel0_tag
- rel0_tag  in  TAG_W  tag returned to pool
- rel1_valid  in  1  retire slot 1 releases rel1_tag
- rel1_tag  in  TAG_W  tag returned to pool
- free_count  out  TAG_W+1  registered number of free tags
- empty  out  1  free_count == 0
- err_overflow  out  1  sticky: a release was attempted with the pool full

## Operation
- Storage: circular FIFO of NUM_PREGS entries of TAG_W bits, head pointer (pop), tail pointer (push), count register; pointers TAG_W bits, wrap modulo NUM_PREGS.
- Reset: entry i = NUM_ARCH+i for i in 0..NUM_PREGS-NUM_ARCH-1, other entries 0; head=0, tail=NUM_PREGS-NUM_ARCH (32), free_count=32, err_overflow=0.
- Grant rule (in-order, no slot-1 bypass of slot 0):
  - alloc0_gnt = alloc0_req && count>=1; alloc0_tag = fifo[head].
  - If alloc0_req: alloc1_gnt = alloc1_req && count>=2; alloc1_tag = fifo[head+1].
  - If !alloc0_req: alloc1_gnt = alloc1_req && count>=1; alloc1_tag = fifo[head].
  - Slot 1 never granted while slot 0 is requesting and denied.
- Grants use registered count only; tags released this cycle are not allocatable this cycle (no bypass).
- Release: rel0 pushed at tail, rel1 at tail+1 if rel0_valid else at tail; order rel0 then rel1.
- Update on posedge: head += grants; tail += accepted releases; count += accepted releases − grants.
- Overflow: a release is accepted only if count − grants + prior accepted releases < NUM_PREGS; a rejected release is dropped and sets err_overflow (cleared only by rst).
- No duplicate-tag checking; retire guarantees uniqueness.
- Outputs with no grant: alloc*_tag still shows the candidate entry; consumers qualify with gnt.

## Timing
- Allocation latency 0: gnt/tag combinational from request in cycle N; pop takes effect at posedge ending N; popped tag absent from N+1.
- Release latency 1: tag pushed at posedge ending N; counted in free_count from N+1; allocatable from N+1 once it reaches head.
- Simultaneous alloc+release at count 0: alloc denied in N, release visible N+1.
- Wrap-around: pointers wrap 63→0 with no bubble.
- rst asserted mid-cycle: state returns immediately to reset values; grants deasserted while rst high.

## Configuration
- PREG_FREE_LIST_STATS_EN defined: adds output stall_cnt (16 bits, reset 0) incrementing once per cycle in which any asserted request is denied, saturating at 0xFFFF.
- Undefined: port and counter absent; all other behaviour identical.

## Test plan
- Reset release, no traffic -> free_count=32, empty=0, err_overflow=0, slot tags read 32 (slot 0) and 33 (slot 1 with both requesting).
- Both slots request 16 consecutive cycles -> tags 32..63 in order, slot 0 always even, free_count=0, empty=1; 17th cycle both gnt=0.
- Empty pool, only alloc1_req, rel0 of tag 5 in cycle N -> alloc1_gnt=0 in N, =1 with tag 5 in N+1.
- Count=1, both slots request -> alloc0_gnt=1 (tag at head), alloc1_gnt=0; with only alloc1_req -> alloc1_gnt=1.
- Reset state, release tags 0..31 two per cycle then one more release -> free_count=64, extra release dropped, err_overflow=1 until rst.
- Alloc/release streaming 200 cycles through pointer wrap -> tags returned FIFO order, free_count matches model; with STATS_EN, stall_cnt equals denied-request cycles.
